// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, state codes
// and datapath mux-select values.
package mips_multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_I_EXEC    = 4'd8;
   localparam logic [3:0] S_I_WB      = 4'd9;
   localparam logic [3:0] S_BRANCH    = 4'd10;
   localparam logic [3:0] S_JUMP      = 4'd11;

   localparam logic [1:0] ALU_OP_ADD   = 2'd0;
   localparam logic [1:0] ALU_OP_SUB   = 2'd1;
   localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // States that hold a memory access open and therefore run the wait counter.
   function automatic logic is_wait_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags an abort once the
// count has reached TIMEOUT with the access still outstanding.
module mem_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   input  logic ready,
   output logic timeout
);

   logic [CNT_W-1:0] cnt_r;
   logic             at_limit_s;

   assign at_limit_s = (cnt_r == CNT_W'(TIMEOUT));
   // Ready arriving on the limit cycle wins, so the abort needs ready low.
   assign timeout    = waiting & ~ready & at_limit_s;

   // Wait counter: saturates at TIMEOUT, cleared on every state entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (waiting && !ready && !at_limit_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with memory-ready
// stalls and a timeout abort on stuck accesses.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_err
);

   logic [3:0] state_r;
   logic [3:0] next_state_s;
   logic       timeout_s;
   logic       clear_s;
   logic       pc_write_s;
   logic       pc_write_cond_s;

   // Any state change restarts the count; an abort from FETCH stays in FETCH.
   assign clear_s = (next_state_s != state_r) | timeout_s;

   mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_s),
      .waiting (is_wait_state(state_r)),
      .ready   (mem_ready),
      .timeout (timeout_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; unused encodings fall back to FETCH.
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH:     next_state_s = (mem_ready && !timeout_s) ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     next_state_s = S_R_EXEC;
               OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_J:         next_state_s = S_JUMP;
               OP_ADDI:      next_state_s = S_I_EXEC;
               default:      next_state_s = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  next_state_s = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (timeout_s)      next_state_s = S_FETCH;
            else if (mem_ready) next_state_s = S_MEM_WB;
            else                next_state_s = S_MEM_READ;
         end
         S_MEM_WRITE: next_state_s = (mem_ready || timeout_s) ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    next_state_s = S_R_WB;
         S_I_EXEC:    next_state_s = S_I_WB;
         default:     next_state_s = S_FETCH;
      endcase
   end

   // Output decode; reset and a timeout abort both force every strobe low.
   always_comb begin
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      iord            = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      ir_write        = 1'b0;
      reg_dst         = 1'b0;
      mem_to_reg      = 1'b0;
      reg_write       = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = SRCB_B;
      alu_op          = ALU_OP_ADD;
      pc_source       = PCSRC_ALU;
      illegal_op      = 1'b0;
      mem_err         = 1'b0;
      if (!reset && timeout_s) begin
         mem_err = 1'b1;
      end else if (!reset) begin
         case (state_r)
            S_FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = SRCB_FOUR;
               ir_write   = mem_ready;
               pc_write_s = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMM_SH2;
               case (opcode)
                  OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                  default:                                       illegal_op = 1'b1;
               endcase
            end
            S_MEM_ADDR, S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_I_WB:      reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a       = 1'b1;
               alu_op          = ALU_OP_SUB;
               pc_source       = PCSRC_ALUOUT;
               pc_write_cond_s = 1'b1;
            end
            S_JUMP: begin
               pc_source  = PCSRC_JUMP;
               pc_write_s = 1'b1;
            end
            default: mem_err = 1'b0;
         endcase
      end else begin
         mem_err = 1'b0;
      end
      pc_en = pc_write_s | (pc_write_cond_s & zero);
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle state and output-vector
// checks against hand-computed expectations.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, illegal_op, mem_err;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [16:0] outs;

   int errs   = 0;
   int checks = 0;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   assign outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, mem_err};

   function automatic logic [16:0] ov(input logic pe, io, mr, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, aop, psrc,
                                      input logic ill, merr);
      return {pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill, merr};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [16:0] v_fetch, v_fnr, v_dec, v_ill, v_maddr, v_mrd, v_mwb, v_mwr, v_abort;
   logic [16:0] v_rex, v_rwb, v_iwb, v_beq1, v_beq0, v_jmp;

   // Check state and outputs 1 time unit after the negedge, then move to the next negedge.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] exp);
      #1;
      check({tag, " state"}, {28'd0, dut.state_r}, {28'd0, st});
      check({tag, " outs"}, {15'd0, outs}, {15'd0, exp});
      @(negedge clk);
   endtask

   task automatic front(input string tag, input logic [5:0] op);
      opcode    = op;
      mem_ready = 1'b1;
      cyc({tag, " fetch"}, 4'd0, v_fetch);
      cyc({tag, " decode"}, 4'd1, (op == 6'h3F) ? v_ill : v_dec);
   endtask

   initial begin
      v_fetch = ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
      v_fnr   = ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
      v_dec   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0);
      v_ill   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);
      v_maddr = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
      v_mrd   = ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v_mwb   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v_mwr   = ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v_abort = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
      v_rex   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
      v_rwb   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v_iwb   = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v_beq1  = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
      v_beq0  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
      v_jmp   = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0);

      reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("reset outs", {15'd0, outs}, 32'd0);
      check("reset state", {28'd0, dut.state_r}, 32'd0);
      mem_ready = 1'b1; opcode = 6'h23;
      #1 check("reset outs ready", {15'd0, outs}, 32'd0);
      reset = 1'b0;
      #1;
      @(negedge clk);
      // The first FETCH cycle was consumed above; restart from a clean instruction boundary.
      // That cycle fetched lw and moved to DECODE.
      cyc("lw0 decode", 4'd1, v_dec);
      cyc("lw0 addr", 4'd2, v_maddr);
      cyc("lw0 read", 4'd3, v_mrd);
      cyc("lw0 wb", 4'd4, v_mwb);

      front("lw", 6'h23);
      cyc("lw addr", 4'd2, v_maddr);
      cyc("lw read", 4'd3, v_mrd);
      cyc("lw wb", 4'd4, v_mwb);

      front("sw", 6'h2B);
      cyc("sw addr", 4'd2, v_maddr);
      cyc("sw write", 4'd5, v_mwr);

      front("rtype", 6'h00);
      cyc("rtype exec", 4'd6, v_rex);
      cyc("rtype wb", 4'd7, v_rwb);

      front("addi", 6'h08);
      cyc("addi exec", 4'd8, v_maddr);
      cyc("addi wb", 4'd9, v_iwb);

      zero = 1'b1;
      front("beq1", 6'h04);
      cyc("beq1 branch", 4'd10, v_beq1);
      zero = 1'b0;
      front("beq0", 6'h04);
      cyc("beq0 branch", 4'd10, v_beq0);

      front("j", 6'h02);
      cyc("j jump", 4'd11, v_jmp);

      opcode = 6'h02; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("stall wait", 4'd0, v_fnr);
      mem_ready = 1'b1;
      cyc("stall fetch4", 4'd0, v_fetch);
      cyc("stall decode", 4'd1, v_dec);
      cyc("stall jump", 4'd11, v_jmp);

      front("ill", 6'h3F);

      front("to", 6'h2B);
      cyc("to addr", 4'd2, v_maddr);
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) cyc("to wait", 4'd5, v_mwr);
      cyc("to abort", 4'd5, v_abort);
      cyc("to after1", 4'd0, v_fnr);
      cyc("to after2", 4'd0, v_fnr);

      front("tie", 6'h2B);
      cyc("tie addr", 4'd2, v_maddr);
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) cyc("tie wait", 4'd5, v_mwr);
      mem_ready = 1'b1;
      cyc("tie done", 4'd5, v_mwr);

      mem_ready = 1'b0; opcode = 6'h00;
      for (int i = 0; i < 16; i++) cyc("fto wait", 4'd0, v_fnr);
      cyc("fto abort", 4'd0, v_abort);
      cyc("fto refetch", 4'd0, v_fnr);

      front("rst", 6'h2B);
      cyc("rst addr", 4'd2, v_maddr);
      mem_ready = 1'b0;
      #1 check("rst mw before", {31'd0, mem_write}, 32'd1);
      #1 reset = 1'b1;
      #1 check("rst async outs", {15'd0, outs}, 32'd0);
      check("rst async state", {28'd0, dut.state_r}, 32'd0);
      @(negedge clk);
      #1 check("rst held outs", {15'd0, outs}, 32'd0);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1;
      cyc("rst fetch", 4'd0, v_fetch);
      cyc("rst decode", 4'd1, v_dec);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
